btb_resolve_ctrl: RTL and testbench

- Update-side counterpart to the BTB.
- Tracks every fetched instruction's BTB prediction in an in-order queue and compares it against the execute-stage resolution.
- Drives the BTB update interface (update_pc, update, update_target, mispredicted) and the fetch redirect/flush.
- Sits between the fetch stage (push side) and the execute stage (resolve side).

---
 rtl/btb_resolve_ctrl.sv | 169 ++++++++++++++++
 tb/tb_btb_resolve_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_resolve_ctrl.sv
// btb_resolve_ctrl: update-side companion of the BTB.
// Keeps every fetched instruction's BTB prediction in an in-order queue,
// compares it with the execute-stage resolution, and drives the BTB update
// port plus the fetch redirect/flush pulses. All outputs are registered,
// so they appear one cycle after the resolve.
// Optional feature macro: BTB_STATS_EN adds saturating branch/mispredict
// counters (stat_branches, stat_mispredicts).
module btb_resolve_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [31:0]      push_pc,
  input  logic             push_pred_taken,
  input  logic [31:0]      push_pred_target,
  output logic             push_ready,
  input  logic             resolve_valid,
  input  logic             resolve_is_branch,
  input  logic             resolve_taken,
  input  logic [31:0]      resolve_target,
  output logic             update,
  output logic [31:0]      update_pc,
  output logic [31:0]      update_target,
  output logic             mispredicted,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
`ifdef BTB_STATS_EN
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts,
`endif
  output logic [PTR_W:0]   count,
  output logic             resolve_err
);

  localparam logic [PTR_W:0] DepthC = (PTR_W+1)'(DEPTH);

  // Prediction storage; validity is tracked by the pointers and count alone
  logic [31:0]      pc_mem_q     [DEPTH];
  logic             taken_mem_q  [DEPTH];
  logic [31:0]      target_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             update_q;
  logic [31:0]      update_pc_q;
  logic [31:0]      update_target_q;
  logic             mispredicted_q;
  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;
  logic             flush_q;
  logic             resolve_err_q;

  logic [31:0]      head_pc;
  logic             head_taken;
  logic [31:0]      head_target;
  logic             resolve_ok;
  logic             mis;
  logic             flush_now;
  logic             pop_ok;
  logic             push_acc;

  // Head compare, mispredict detection and next pointer/occupancy state
  always_comb begin
    head_pc     = pc_mem_q[rd_ptr_q];
    head_taken  = taken_mem_q[rd_ptr_q];
    head_target = target_mem_q[rd_ptr_q];
    resolve_ok  = resolve_valid && (count_q != '0);
    mis         = (head_taken != resolve_taken) ||
                  (head_taken && resolve_taken && (head_target != resolve_target));
    flush_now   = resolve_ok && mis;
    pop_ok      = resolve_ok && !mis;
    // A full queue still takes a push when the head retires in the same cycle
    push_acc    = push_valid && !flush_now && ((count_q != DepthC) || pop_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_now) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_acc && !pop_ok)      count_d = count_q + (PTR_W+1)'(1);
      else if (pop_ok && !push_acc) count_d = count_q - (PTR_W+1)'(1);
    end
  end

  // Capture accepted pushes into the slot under the write pointer
  always_ff @(posedge clk) begin
    if (push_acc) begin
      pc_mem_q[wr_ptr_q]     <= push_pc;
      taken_mem_q[wr_ptr_q]  <= push_pred_taken;
      target_mem_q[wr_ptr_q] <= push_pred_target;
    end
  end

  // Queue control and registered update/redirect outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      update_q         <= 1'b0;
      update_pc_q      <= '0;
      update_target_q  <= '0;
      mispredicted_q   <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      resolve_err_q    <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      update_q         <= resolve_ok && (resolve_is_branch || mis);
      mispredicted_q   <= flush_now;
      redirect_valid_q <= flush_now;
      flush_q          <= flush_now;
      if (resolve_ok) begin
        update_pc_q     <= head_pc;
        update_target_q <= resolve_target;
      end
      if (flush_now) begin
        redirect_pc_q <= resolve_taken ? resolve_target : (head_pc + 32'd4);
      end
      if (resolve_valid && (count_q == '0)) begin
        resolve_err_q <= 1'b1;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mis_q;

  // Saturating event counters driven by the registered output pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (update_q && (stat_br_q != 32'hFFFF_FFFF))        stat_br_q  <= stat_br_q + 32'd1;
      if (mispredicted_q && (stat_mis_q != 32'hFFFF_FFFF)) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
`endif

  assign push_ready     = (count_q != DepthC);
  assign update         = update_q;
  assign update_pc      = update_pc_q;
  assign update_target  = update_target_q;
  assign mispredicted   = mispredicted_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign count          = count_q;
  assign resolve_err    = resolve_err_q;

endmodule

// File: tb/tb_btb_resolve_ctrl.sv
// tb_btb_resolve_ctrl: table-driven bench for btb_resolve_ctrl (DEPTH=4),
// plus hand-written sequences for reset and asynchronous mid-pulse reset.
module tb_btb_resolve_ctrl;

  logic        clk;
  logic        rst;
  logic        push_valid;
  logic [31:0] push_pc;
  logic        push_pred_taken;
  logic [31:0] push_pred_target;
  logic        push_ready;
  logic        resolve_valid;
  logic        resolve_is_branch;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        update;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        mispredicted;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [2:0]  count;
  logic        resolve_err;
`ifdef BTB_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int total;
  int bad;
  int expBranches;
  int expMispredicts;

  btb_resolve_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .push_valid        (push_valid),
    .push_pc           (push_pc),
    .push_pred_taken   (push_pred_taken),
    .push_pred_target  (push_pred_target),
    .push_ready        (push_ready),
    .resolve_valid     (resolve_valid),
    .resolve_is_branch (resolve_is_branch),
    .resolve_taken     (resolve_taken),
    .resolve_target    (resolve_target),
    .update            (update),
    .update_pc         (update_pc),
    .update_target     (update_target),
    .mispredicted      (mispredicted),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .flush             (flush),
`ifdef BTB_STATS_EN
    .stat_branches     (stat_branches),
    .stat_mispredicts  (stat_mispredicts),
`endif
    .count             (count),
    .resolve_err       (resolve_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] ppc;
    logic        pt;
    logic [31:0] ptg;
    logic        rv;
    logic        rb;
    logic        rt;
    logic [31:0] rtg;
    logic        eu;
    logic [31:0] epc;
    logic [31:0] etg;
    logic        em;
    logic [31:0] erpc;
    logic [2:0]  ecnt;
    logic        erdy;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pv, logic [31:0] ppc, logic pt, logic [31:0] ptg,
                              logic rv, logic rb, logic rt, logic [31:0] rtg,
                              logic eu, logic [31:0] epc, logic [31:0] etg, logic em,
                              logic [31:0] erpc, logic [2:0] ecnt, logic erdy, logic eerr);
    vec_t v;
    v.pv = pv;  v.ppc = ppc;  v.pt = pt;  v.ptg = ptg;
    v.rv = rv;  v.rb = rb;    v.rt = rt;  v.rtg = rtg;
    v.eu = eu;  v.epc = epc;  v.etg = etg; v.em = em;
    v.erpc = erpc; v.ecnt = ecnt; v.erdy = erdy; v.eerr = eerr;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    push_valid        = v.pv;
    push_pc           = v.ppc;
    push_pred_taken   = v.pt;
    push_pred_target  = v.ptg;
    resolve_valid     = v.rv;
    resolve_is_branch = v.rb;
    resolve_taken     = v.rt;
    resolve_target    = v.rtg;
  endtask

  task automatic idleInputs();
    push_valid        = 1'b0;
    push_pc           = '0;
    push_pred_taken   = 1'b0;
    push_pred_target  = '0;
    resolve_valid     = 1'b0;
    resolve_is_branch = 1'b0;
    resolve_taken     = 1'b0;
    resolve_target    = '0;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    checkVal({tag, ".update"}, 32'(update), 32'(v.eu));
    checkVal({tag, ".mispredicted"}, 32'(mispredicted), 32'(v.em));
    checkVal({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(v.em));
    checkVal({tag, ".flush"}, 32'(flush), 32'(v.em));
    checkVal({tag, ".count"}, 32'(count), 32'(v.ecnt));
    checkVal({tag, ".push_ready"}, 32'(push_ready), 32'(v.erdy));
    checkVal({tag, ".resolve_err"}, 32'(resolve_err), 32'(v.eerr));
    if (v.eu) begin
      checkVal({tag, ".update_pc"}, update_pc, v.epc);
      checkVal({tag, ".update_target"}, update_target, v.etg);
    end
    if (v.em) begin
      checkVal({tag, ".redirect_pc"}, redirect_pc, v.erpc);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, ".update"}, 32'(update), 32'd0);
    checkVal({tag, ".update_pc"}, update_pc, 32'd0);
    checkVal({tag, ".update_target"}, update_target, 32'd0);
    checkVal({tag, ".mispredicted"}, 32'(mispredicted), 32'd0);
    checkVal({tag, ".redirect_valid"}, 32'(redirect_valid), 32'd0);
    checkVal({tag, ".redirect_pc"}, redirect_pc, 32'd0);
    checkVal({tag, ".flush"}, 32'(flush), 32'd0);
    checkVal({tag, ".count"}, 32'(count), 32'd0);
    checkVal({tag, ".push_ready"}, 32'(push_ready), 32'd1);
    checkVal({tag, ".resolve_err"}, 32'(resolve_err), 32'd0);
`ifdef BTB_STATS_EN
    checkVal({tag, ".stat_branches"}, stat_branches, 32'd0);
    checkVal({tag, ".stat_mispredicts"}, stat_mispredicts, 32'd0);
`endif
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    expBranches    = 0;
    expMispredicts = 0;

    //        pv  ppc            pt  ptg           rv rb rt rtg           eu epc            etg           em erpc          cnt rdy err
    vecs.push_back(mk(1, 32'h100, 1, 32'h200,      0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        1, 1, 1, 32'h200,      1, 32'h100,       32'h200,      0, 32'h0,        0, 1, 0));
    vecs.push_back(mk(1, 32'h104, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        1, 1, 1, 32'h300,      1, 32'h104,       32'h300,      1, 32'h300,      0, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        0, 1, 0));
    vecs.push_back(mk(1, 32'h108, 1, 32'h400,      0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        1, 0, 0, 32'h0,        1, 32'h108,       32'h0,        1, 32'h10C,      0, 1, 0));
    // fill to full, then push+pop while full, wrap both pointers
    vecs.push_back(mk(1, 32'h200, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        1, 1, 0));
    vecs.push_back(mk(1, 32'h204, 1, 32'h500,      0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        2, 1, 0));
    vecs.push_back(mk(1, 32'h208, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        3, 1, 0));
    vecs.push_back(mk(1, 32'h20C, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        4, 0, 0));
    vecs.push_back(mk(1, 32'h210, 0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h200,       32'h0,        0, 32'h0,        4, 0, 0));
    vecs.push_back(mk(1, 32'h214, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        4, 0, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        1, 1, 1, 32'h500,      1, 32'h204,       32'h500,      0, 32'h0,        3, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h208,       32'h0,        0, 32'h0,        2, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h210,       32'h0,        0, 32'h0,        0, 1, 0));
    // streaming push+pop, then mispredict with three queued and a concurrent push
    vecs.push_back(mk(1, 32'h300, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        1, 1, 0));
    vecs.push_back(mk(1, 32'h304, 0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h300,       32'h0,        0, 32'h0,        1, 1, 0));
    vecs.push_back(mk(1, 32'h308, 0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h304,       32'h0,        0, 32'h0,        1, 1, 0));
    vecs.push_back(mk(1, 32'h30C, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        2, 1, 0));
    vecs.push_back(mk(1, 32'h310, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        3, 1, 0));
    vecs.push_back(mk(1, 32'h314, 0, 32'h0,        1, 1, 1, 32'h600,      1, 32'h308,       32'h600,      1, 32'h600,      0, 1, 0));
    vecs.push_back(mk(1, 32'h700, 1, 32'h704,      0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        1, 1, 1, 32'h704,      1, 32'h700,       32'h704,      0, 32'h0,        0, 1, 0));
    // taken-but-wrong-target, and fall-through address wrapping past 2^32
    vecs.push_back(mk(1, 32'h800, 1, 32'h900,      0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        1, 1, 1, 32'h904,      1, 32'h800,       32'h904,      1, 32'h904,      0, 1, 0));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 1, 32'h10, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        1, 0, 0, 32'h55,       1, 32'hFFFF_FFFC, 32'h55,       1, 32'h0,        0, 1, 0));
    // resolve against an empty queue, error must stick
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        1, 1, 1, 32'h999,      0, 32'h0,         32'h0,        0, 32'h0,        0, 1, 1));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 32'h0,        0, 1, 1));

    idleInputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(i, vecs[i]);
      if (vecs[i].eu) expBranches++;
      if (vecs[i].em) expMispredicts++;
      @(negedge clk);
    end
    idleInputs();
    @(posedge clk);
    #1;
`ifdef BTB_STATS_EN
    checkVal("stat_branches", stat_branches, 32'(expBranches));
    checkVal("stat_mispredicts", stat_mispredicts, 32'(expMispredicts));
`endif
    checkVal("err_sticky", 32'(resolve_err), 32'd1);

    // asynchronous reset while a mispredict pulse is on the outputs
    @(negedge clk);
    push_valid = 1'b1; push_pc = 32'h900; push_pred_taken = 1'b0; push_pred_target = '0;
    @(negedge clk);
    idleInputs();
    resolve_valid = 1'b1; resolve_is_branch = 1'b1; resolve_taken = 1'b1; resolve_target = 32'hA00;
    @(posedge clk);
    #1;
    idleInputs();
    checkVal("pre_reset.flush", 32'(flush), 32'd1);
    checkVal("pre_reset.redirect_pc", redirect_pc, 32'hA00);
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(negedge clk);
    rst = 1'b1;
    push_valid = 1'b1; push_pc = 32'hB00; push_pred_taken = 1'b1; push_pred_target = 32'hB40;
    @(posedge clk);
    #1;
    idleInputs();
    checkVal("post_reset.count", 32'(count), 32'd1);
    @(negedge clk);
    resolve_valid = 1'b1; resolve_is_branch = 1'b1; resolve_taken = 1'b1; resolve_target = 32'hB40;
    @(posedge clk);
    #1;
    idleInputs();
    checkVal("post_reset.update", 32'(update), 32'd1);
    checkVal("post_reset.update_pc", update_pc, 32'hB00);
    checkVal("post_reset.mispredicted", 32'(mispredicted), 32'd0);
    checkVal("post_reset.count0", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
